// File: rtl/pkt_fetch.sv
// pkt_fetch: queues cached-packet IDs and requests them one at a time,
// then relays the returned packet words and end-of-packet status to egress.
module pkt_fetch #(
  parameter int ID_FIFO_DEPTH = 16,
  parameter int HEAD_TIMEOUT  = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_pkt_fetch_ID,
  input  logic         in_pkt_fetch_ID_wr,
  output logic [7:0]   out_pkt_fetch_ID,
  output logic         out_pkt_fetch_ID_wr,
  input  logic [133:0] in_pkt_fetch_data,
  input  logic         in_pkt_fetch_data_wr,
  input  logic         in_pkt_fetch_valid,
  input  logic         in_pkt_fetch_valid_wr,
  output logic [133:0] out_pkt_fetch_data,
  output logic         out_pkt_fetch_data_wr,
  output logic         out_pkt_fetch_valid,
  output logic         out_pkt_fetch_valid_wr,
  input  logic         in_pkt_fetch_alf,
  output logic         out_pkt_fetch_ID_full,
  output logic [31:0]  out_pkt_fetch_pkt_cnt,
  output logic [31:0]  out_pkt_fetch_drop_cnt,
  output logic [31:0]  out_pkt_fetch_err_cnt
);

  localparam int AW = $clog2(ID_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(HEAD_TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(ID_FIFO_DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(HEAD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_HEAD,
    S_XFER,
    S_WAIT_VALID
  } state_e;

  state_e state_q, state_d;

  logic [7:0]    mem_q [ID_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          drop;
  logic          pop;

  logic [TW-1:0] timer_q, timer_d;

  logic [7:0]    id_q, id_d;
  logic          id_wr_q, id_wr_d;
  logic [133:0]  data_q, data_d;
  logic          data_wr_q, data_wr_d;
  logic          valid_q, valid_d;
  logic          valid_wr_q, valid_wr_d;

  logic [31:0]   pkt_cnt_q, pkt_cnt_d;
  logic [31:0]   drop_cnt_q, drop_cnt_d;
  logic [31:0]   err_cnt_q, err_cnt_d;
  logic          pkt_inc;
  logic [1:0]    err_inc;

  logic          is_head;
  logic          is_tail;

  assign is_head = (in_pkt_fetch_data[133:132] == 2'b01);
  assign is_tail = (in_pkt_fetch_data[133:132] == 2'b10);

  // Fullness is judged on the occupancy before any same-cycle pop.
  assign fifo_full  = (cnt_q == DEPTH_C);
  assign fifo_empty = (cnt_q == '0);
  assign push       = in_pkt_fetch_ID_wr && !fifo_full;
  assign drop       = in_pkt_fetch_ID_wr && fifo_full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_pkt_fetch_ID;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    pop        = 1'b0;
    id_d       = id_q;
    id_wr_d    = 1'b0;
    data_d     = data_q;
    data_wr_d  = 1'b0;
    valid_d    = valid_q;
    valid_wr_d = 1'b0;
    pkt_inc    = 1'b0;
    err_inc    = 2'd0;
    unique case (state_q)
      S_IDLE: begin
        if (in_pkt_fetch_data_wr) err_inc = err_inc + 2'd1;
        if (in_pkt_fetch_valid_wr) err_inc = err_inc + 2'd1;
        if (!fifo_empty && !in_pkt_fetch_alf) begin
          pop     = 1'b1;
          id_d    = mem_q[rd_ptr_q];
          id_wr_d = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (in_pkt_fetch_data_wr) err_inc = err_inc + 2'd1;
        if (in_pkt_fetch_valid_wr) err_inc = err_inc + 2'd1;
        timer_d = '0;
        state_d = S_WAIT_HEAD;
      end
      S_WAIT_HEAD: begin
        if (in_pkt_fetch_valid_wr) err_inc = err_inc + 2'd1;
        if (in_pkt_fetch_data_wr && is_head) begin
          data_d    = in_pkt_fetch_data;
          data_wr_d = 1'b1;
          state_d   = S_XFER;
        end else begin
          if (in_pkt_fetch_data_wr) err_inc = err_inc + 2'd1;
          if (timer_q == TO_LAST) begin
            err_inc = err_inc + 2'd1;
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      S_XFER: begin
        // A second head means the cache lost track; close the packet as bad.
        if (in_pkt_fetch_data_wr && is_head) begin
          err_inc    = err_inc + 2'd1;
          valid_wr_d = 1'b1;
          valid_d    = 1'b0;
          state_d    = S_IDLE;
        end else begin
          if (in_pkt_fetch_data_wr) begin
            data_d    = in_pkt_fetch_data;
            data_wr_d = 1'b1;
            if (is_tail) state_d = S_WAIT_VALID;
          end
          if (in_pkt_fetch_valid_wr && in_pkt_fetch_data_wr && is_tail) begin
            valid_wr_d = 1'b1;
            valid_d    = in_pkt_fetch_valid;
            pkt_inc    = in_pkt_fetch_valid;
            state_d    = S_IDLE;
          end else if (in_pkt_fetch_valid_wr) begin
            err_inc = err_inc + 2'd1;
          end
        end
      end
      S_WAIT_VALID: begin
        if (in_pkt_fetch_data_wr) err_inc = err_inc + 2'd1;
        if (in_pkt_fetch_valid_wr) begin
          valid_wr_d = 1'b1;
          valid_d    = in_pkt_fetch_valid;
          pkt_inc    = in_pkt_fetch_valid;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pkt_cnt_d  = pkt_cnt_q + {31'd0, pkt_inc};
  assign drop_cnt_d = drop_cnt_q + {31'd0, drop};
  assign err_cnt_d  = err_cnt_q + {30'd0, err_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
      id_q       <= '0;
      id_wr_q    <= 1'b0;
      data_q     <= '0;
      data_wr_q  <= 1'b0;
      valid_q    <= 1'b0;
      valid_wr_q <= 1'b0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      id_q       <= id_d;
      id_wr_q    <= id_wr_d;
      data_q     <= data_d;
      data_wr_q  <= data_wr_d;
      valid_q    <= valid_d;
      valid_wr_q <= valid_wr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_pkt_fetch_ID       = id_q;
  assign out_pkt_fetch_ID_wr    = id_wr_q;
  assign out_pkt_fetch_data     = data_q;
  assign out_pkt_fetch_data_wr  = data_wr_q;
  assign out_pkt_fetch_valid    = valid_q;
  assign out_pkt_fetch_valid_wr = valid_wr_q;
  assign out_pkt_fetch_ID_full  = fifo_full;
  assign out_pkt_fetch_pkt_cnt  = pkt_cnt_q;
  assign out_pkt_fetch_drop_cnt = drop_cnt_q;
  assign out_pkt_fetch_err_cnt  = err_cnt_q;

endmodule

// File: doc/pkt_fetch.md
PKT_FETCH -- requirements
Module: pkt_fetch

Interface
REQ-001 SHALL have parameter ID_FIFO_DEPTH, default 16, meaning number of pending packet IDs held (power of two, 4..64).
REQ-002 SHALL have parameter HEAD_TIMEOUT, default 1023, meaning the maximum cycles to wait for a packet head after a read request.
REQ-003 SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_pkt_fetch_ID / in_pkt_fetch_ID_wr  in  8/1  a cached-packet ID to fetch, qualified by the 1-cycle strobe.
REQ-006 SHALL have port out_pkt_fetch_ID / out_pkt_fetch_ID_wr  out  8/1  the read request to the data cache.
REQ-007 SHALL have port in_pkt_fetch_data / in_pkt_fetch_data_wr  in  134/1  the packet word from the cache.
REQ-008 SHALL have port in_pkt_fetch_valid / in_pkt_fetch_valid_wr  in  1/1  the end-of-packet status from the cache.
REQ-009 SHALL have port out_pkt_fetch_data / out_pkt_fetch_data_wr  out  134/1  the packet word to egress.
REQ-010 SHALL have port out_pkt_fetch_valid / out_pkt_fetch_valid_wr  out  1/1  the end-of-packet status to egress.
REQ-011 SHALL have port in_pkt_fetch_alf  in  1  egress almost-full.
REQ-012 SHALL have port out_pkt_fetch_ID_full  out  1  ID FIFO full.
REQ-013 SHALL have port out_pkt_fetch_pkt_cnt / out_pkt_fetch_drop_cnt / out_pkt_fetch_err_cnt  out  32 each  the forwarded, dropped-ID and error counters.

Function
REQ-014 SHALL use word format [133:132] 01=head, 11=middle, 10=tail, [131:128] invalid-byte count, [127:0] payload.
REQ-015 SHALL push in_pkt_fetch_ID into the ID FIFO on in_pkt_fetch_ID_wr when the FIFO is not full.
REQ-016 SHALL discard the ID and increment drop_cnt when in_pkt_fetch_ID_wr arrives while full; fullness is evaluated before any same-cycle pop.
REQ-017 SHALL assert out_pkt_fetch_ID_full combinationally from FIFO occupancy == ID_FIFO_DEPTH.
REQ-018 SHALL implement the FSM states IDLE, REQ, WAIT_HEAD, XFER and WAIT_VALID.
REQ-019 SHALL go IDLE->REQ when the FIFO is non-empty and in_pkt_fetch_alf=0, popping the FIFO head into the request register.
REQ-020 SHALL, in REQ, drive out_pkt_fetch_ID_wr=1 for exactly one cycle with the popped ID, then go to WAIT_HEAD and clear the timeout counter.
REQ-021 SHALL, in WAIT_HEAD, go to XFER on data_wr with a head flag.
REQ-022 SHALL, in WAIT_HEAD, drop any non-head word and increment err_cnt.
REQ-023 SHALL, in WAIT_HEAD, increment err_cnt and go to IDLE when the counter reaches HEAD_TIMEOUT.
REQ-024 SHALL, in XFER, forward every data_wr word; a tail word goes to WAIT_VALID.
REQ-025 SHALL treat a head word in XFER as an error: increment err_cnt, force out_pkt_fetch_valid_wr=1 with valid=0 to close the packet, and go to IDLE.
REQ-026 SHALL, in WAIT_VALID (also accepted in the tail cycle itself), forward valid_wr/valid, increment pkt_cnt when valid=1, and go to IDLE.
REQ-027 SHALL have a fixed latency of 1 cycle, registered, from in data_wr/valid_wr to the corresponding out strobes, with data unchanged.
REQ-028 SHALL ignore data_wr and valid_wr in IDLE or REQ and increment err_cnt for each.
REQ-029 SHALL have at most one outstanding request; alf is sampled only in IDLE, and an in-flight packet always completes.
REQ-030 SHALL let all counters wrap modulo 2^32.
REQ-031 SHALL wrap FIFO pointers modulo ID_FIFO_DEPTH.

Reset
REQ-032 SHALL, while rst=1, put the FSM in IDLE, empty the FIFO, set all out_* strobes, data and valid to 0, and clear all counters to 0.
REQ-033 SHALL, on rst mid-packet, abandon the packet and keep every output at 0 from the next cycle, with no valid_wr emitted.

Verification
REQ-034 SHALL verify: ID 0x05 pushed, 3-word packet head/mid/tail returned, valid_wr with valid=1 -> out_ID_wr once with 0x05, 3 data words plus valid=1 each 1 cycle delayed, pkt_cnt=1.
REQ-035 SHALL verify: 17 IDs pushed back-to-back with alf=1 -> ID_full=1 after the 16th, drop_cnt=1, no out_ID_wr.
REQ-036 SHALL verify: one ID pushed and no data returned -> err_cnt=1 after 1023 cycles in WAIT_HEAD, FSM IDLE, the next queued ID requested.
REQ-037 SHALL verify: a head arriving in XFER -> out valid_wr=1 with valid=0, err_cnt=1, no pkt_cnt increment.
REQ-038 SHALL verify: IDs 0x00..0x0F with alternating packets and alf toggling -> requests issued in FIFO order, none while alf=1 in IDLE, in-flight packet completes.
REQ-039 SHALL verify: rst asserted on the 2nd data word -> all outputs 0 the next cycle, counters 0, and a fresh ID after reset fetched normally.
